// File: rtl/hdmi_cfg_pkg.sv
// Shared types and defaults for the HDMI transmitter power-up configuration sequencer.
package hdmi_cfg_pkg;

  localparam int         CFG_ENTRY_W         = 16;  // {reg, data}
  localparam int         ENTRY_IDX_W         = 4;
  localparam int         DEFAULT_NUM_ENTRIES = 14;
  localparam logic [7:0] DEFAULT_DEV_ADDR    = 8'h72;

  typedef enum logic [2:0] {
    PWRUP_WAIT = 3'd0,
    ISSUE      = 3'd1,
    WAIT_RSP   = 3'd2,
    RETRY_GAP  = 3'd3,
    NEXT       = 3'd4,
    DONE       = 3'd5,
    ERROR      = 3'd6
  } cfg_state_e;

endpackage

// File: rtl/hdmi_config_rom.sv
// Fixed (register, data) table written to the transmitter at power-up.
module hdmi_config_rom
  import hdmi_cfg_pkg::*;
(
  input  logic [ENTRY_IDX_W-1:0] idx,
  output logic [CFG_ENTRY_W-1:0] entry
);

  always_comb begin
    // NOTE: the default arm assigns entry for every index, so no latch is inferred.
    case (idx)
      4'd0:    entry = 16'h4110;
      4'd1:    entry = 16'h9803;
      4'd2:    entry = 16'h9AE0;
      4'd3:    entry = 16'h9C30;
      4'd4:    entry = 16'h9D61;
      4'd5:    entry = 16'hA2A4;
      4'd6:    entry = 16'hA3A4;
      4'd7:    entry = 16'hE0D0;
      4'd8:    entry = 16'hF900;
      4'd9:    entry = 16'h1500;
      4'd10:   entry = 16'h1630;
      4'd11:   entry = 16'h1702;
      4'd12:   entry = 16'h1846;
      4'd13:   entry = 16'hAF06;
      default: entry = 16'h0000;
    endcase
  end

endmodule

// File: rtl/hdmi_config_sequencer.sv
// Walks the HDMI transmitter configuration table over the I2C byte-write master,
// with NACK retries, a power-up wait and hot-plug / START triggered re-runs.
module hdmi_config_sequencer
  import hdmi_cfg_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR         = DEFAULT_DEV_ADDR,
  parameter int         NUM_ENTRIES      = DEFAULT_NUM_ENTRIES,
  parameter int         POWERUP_CYCLES   = 1_000_000,
  parameter int         MAX_RETRY        = 3,
  parameter int         RETRY_GAP_CYCLES = 5000
) (
  input  logic                   REF_CLK,
  input  logic                   RESET_CONFIG,
  input  logic                   START,
  input  logic                   HPD,
  output logic                   CMD_VALID,
  input  logic                   CMD_READY,
  output logic [7:0]             CMD_DEV,
  output logic [7:0]             CMD_REG,
  output logic [7:0]             CMD_DATA,
  input  logic                   RSP_VALID,
  input  logic                   RSP_NACK,
  output logic                   I2C_BUSY,
  output logic                   CONFIG_DONE,
  output logic                   I2C_ERROR_LED,
  output logic [ENTRY_IDX_W-1:0] ENTRY_IDX
);

  localparam int CNT_MAX = (POWERUP_CYCLES > RETRY_GAP_CYCLES) ? POWERUP_CYCLES : RETRY_GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  cfg_state_e             state;
  logic [CNT_W-1:0]       cnt;
  logic [RTY_W-1:0]       retry_cnt;
  logic                   hpd_meta, hpd_sync, hpd_prev;
  logic                   pending;
  logic [CFG_ENTRY_W-1:0] rom_entry;
  logic                   cnt_done;
  logic                   rerun;

  hdmi_config_rom u_rom (
    .idx   (ENTRY_IDX),
    .entry (rom_entry)
  );

  // The wait counter is shared: only one of the two waits can be active at a time.
  always_comb begin
    cnt_done = (state == PWRUP_WAIT) ? (cnt == CNT_W'(POWERUP_CYCLES - 1))
                                     : (cnt == CNT_W'(RETRY_GAP_CYCLES - 1));
    rerun    = pending && ((state == DONE) || (state == ERROR));
  end

  // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge REF_CLK or negedge RESET_CONFIG) begin
    if (!RESET_CONFIG) begin
      state         <= PWRUP_WAIT;
      cnt           <= '0;
      retry_cnt     <= '0;
      hpd_meta      <= 1'b0;
      hpd_sync      <= 1'b0;
      hpd_prev      <= 1'b0;
      pending       <= 1'b0;
      CMD_VALID     <= 1'b0;
      CMD_DEV       <= '0;
      CMD_REG       <= '0;
      CMD_DATA      <= '0;
      I2C_BUSY      <= 1'b1;
      CONFIG_DONE   <= 1'b0;
      I2C_ERROR_LED <= 1'b0;
      ENTRY_IDX     <= '0;
    end else begin
      hpd_meta <= HPD;
      hpd_sync <= hpd_meta;
      hpd_prev <= hpd_sync;

      // A new event wins over the clear so a trigger landing on the re-run edge is kept.
      if (START || (hpd_sync && !hpd_prev)) pending <= 1'b1;
      else if (rerun)                       pending <= 1'b0;

      case (state)
        PWRUP_WAIT, RETRY_GAP: begin
          if (cnt_done) begin
            cnt   <= '0;
            state <= ISSUE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ISSUE: begin
          // Payload is loaded once and then frozen until the handshake completes.
          if (!CMD_VALID) begin
            CMD_VALID           <= 1'b1;
            CMD_DEV             <= DEV_ADDR;
            {CMD_REG, CMD_DATA} <= rom_entry;
          end else if (CMD_READY) begin
            CMD_VALID <= 1'b0;
            state     <= WAIT_RSP;
          end
        end

        WAIT_RSP: begin
          if (RSP_VALID) begin
            if (!RSP_NACK) begin
              retry_cnt <= '0;
              state     <= NEXT;
            end else if (retry_cnt < RTY_W'(MAX_RETRY)) begin
              retry_cnt <= retry_cnt + RTY_W'(1);
              state     <= RETRY_GAP;
            end else begin
              state <= ERROR;
            end
          end
        end

        NEXT: begin
          if (ENTRY_IDX == ENTRY_IDX_W'(NUM_ENTRIES - 1)) begin
            state <= DONE;
          end else begin
            ENTRY_IDX <= ENTRY_IDX + ENTRY_IDX_W'(1);
            state     <= ISSUE;
          end
        end

        DONE, ERROR: begin
          if (pending) begin
            ENTRY_IDX     <= '0;
            retry_cnt     <= '0;
            CONFIG_DONE   <= 1'b0;
            I2C_ERROR_LED <= 1'b0;
            I2C_BUSY      <= 1'b1;
            state         <= ISSUE;
          end else if (state == DONE) begin
            I2C_BUSY    <= 1'b0;
            CONFIG_DONE <= 1'b1;
          end else begin
            I2C_ERROR_LED <= 1'b1;
          end
        end

        default: state <= PWRUP_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_config_sequencer.sv
// Directed-plus-random bench for hdmi_config_sequencer: a responder answers every accepted
// command three cycles later and the accepted command stream is compared with a table model.
module tb_hdmi_config_sequencer;

  localparam int P  = 10;
  localparam int G  = 4;
  localparam int MR = 3;
  localparam int N  = 14;
  localparam logic [15:0] TBL [N] = '{16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61,
                                      16'hA2A4, 16'hA3A4, 16'hE0D0, 16'hF900, 16'h1500,
                                      16'h1630, 16'h1702, 16'h1846, 16'hAF06};

  logic       REF_CLK = 1'b0;
  logic       RESET_CONFIG = 1'b0;
  logic       START = 1'b0;
  logic       HPD = 1'b0;
  logic       CMD_READY = 1'b0;
  logic       RSP_VALID = 1'b0;
  logic       RSP_NACK = 1'b0;
  logic       CMD_VALID;
  logic [7:0] CMD_DEV, CMD_REG, CMD_DATA;
  logic       I2C_BUSY, CONFIG_DONE, I2C_ERROR_LED;
  logic [3:0] ENTRY_IDX;

  hdmi_config_sequencer #(
    .DEV_ADDR         (8'h72),
    .NUM_ENTRIES      (N),
    .POWERUP_CYCLES   (P),
    .MAX_RETRY        (MR),
    .RETRY_GAP_CYCLES (G)
  ) dut (
    .REF_CLK       (REF_CLK),
    .RESET_CONFIG  (RESET_CONFIG),
    .START         (START),
    .HPD           (HPD),
    .CMD_VALID     (CMD_VALID),
    .CMD_READY     (CMD_READY),
    .CMD_DEV       (CMD_DEV),
    .CMD_REG       (CMD_REG),
    .CMD_DATA      (CMD_DATA),
    .RSP_VALID     (RSP_VALID),
    .RSP_NACK      (RSP_NACK),
    .I2C_BUSY      (I2C_BUSY),
    .CONFIG_DONE   (CONFIG_DONE),
    .I2C_ERROR_LED (I2C_ERROR_LED),
    .ENTRY_IDX     (ENTRY_IDX)
  );

  always #5 REF_CLK = ~REF_CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observation state shared between the monitor, responder and the directed sequence.
  int          cyc = 0;
  int          acc_cyc = -100;
  int          last_rise = 0;
  int          nack_entry = 0;
  int          nack_left = 0;
  int          ready_mode = 0;  // 0: always ready, 1: random, 2: stall entry 5 for 7 cycles
  int          bp_cnt = 0;
  bit          rsp_nack_next = 1'b0;
  bit          prev_valid = 1'b0;
  bit          hold_valid = 1'b0;
  logic [23:0] held = '0;
  logic [23:0] acc_q[$];
  logic [23:0] exp_q[$];
  int          acc_cyc_q[$];
  int          rise_q[$];

  // Posedge monitor: handshake log and payload stability while stalled.
  initial forever begin
    @(posedge REF_CLK);
    cyc++;
    if (RESET_CONFIG && hold_valid) begin
      check("stall_valid", 32'(CMD_VALID), 32'd1);
      check("stall_payload", 32'({CMD_DEV, CMD_REG, CMD_DATA}), 32'(held));
    end
    hold_valid = RESET_CONFIG && CMD_VALID && !CMD_READY;
    held       = {CMD_DEV, CMD_REG, CMD_DATA};
    if (RESET_CONFIG && CMD_VALID && CMD_READY) begin
      acc_q.push_back(held);
      acc_cyc_q.push_back(cyc);
      rise_q.push_back(last_rise);
      acc_cyc       = cyc;
      rsp_nack_next = (nack_left > 0) && (held[15:0] == TBL[nack_entry]);
      if (rsp_nack_next) nack_left--;
    end
  end

  // Negedge driver: CMD_READY policy and a responder answering 3 cycles after acceptance.
  initial forever begin
    @(negedge REF_CLK);
    if (CMD_VALID && !prev_valid) last_rise = cyc;
    prev_valid = CMD_VALID;
    case (ready_mode)
      0: CMD_READY = 1'b1;
      1: CMD_READY = ($urandom_range(0, 3) != 0);
      default: begin
        if (CMD_VALID && CMD_REG == 8'hA2 && bp_cnt < 7) begin
          CMD_READY = 1'b0;
          bp_cnt++;
        end else begin
          CMD_READY = 1'b1;
        end
      end
    endcase
    if (cyc == acc_cyc + 2) begin
      RSP_VALID = 1'b1;
      RSP_NACK  = rsp_nack_next;
    end else if (ready_mode == 1 && CMD_VALID && !CMD_READY) begin
      RSP_VALID = 1'($urandom_range(0, 1));
      RSP_NACK  = 1'($urandom_range(0, 1));
    end else begin
      RSP_VALID = 1'b0;
      RSP_NACK  = 1'($urandom_range(0, 1));
    end
  end

  // Reference model: table order, each entry issued once plus once per NACK, stopping on exhaustion.
  task automatic add_sequence(input int nack_e, input int nacks);
    int issues;
    for (int i = 0; i < N; i++) begin
      issues = (i == nack_e) ? nacks + 1 : 1;
      if (issues > MR + 1) issues = MR + 1;
      for (int k = 0; k < issues; k++) exp_q.push_back({8'h72, TBL[i]});
      if (i == nack_e && nacks > MR) return;
    end
  endtask

  task automatic clear_logs();
    acc_q.delete();
    exp_q.delete();
    acc_cyc_q.delete();
    rise_q.delete();
  endtask

  task automatic compare_log(input string tag);
    check($sformatf("%s_count", tag), acc_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
      check($sformatf("%s_cmd%0d", tag, i), 32'(acc_q[i]), 32'(exp_q[i]));
  endtask

  task automatic wait_terminal(input string tag, input int budget);
    int k = 0;
    while (!(CONFIG_DONE || I2C_ERROR_LED) && k < budget) begin
      @(negedge REF_CLK);
      k++;
    end
    check($sformatf("%s_terminal", tag), 32'(CONFIG_DONE || I2C_ERROR_LED), 32'd1);
  endtask

  task automatic wait_size(input string tag, input int n, input int budget);
    int k = 0;
    while (acc_q.size() < n && k < budget) begin
      @(negedge REF_CLK);
      k++;
    end
    check($sformatf("%s_reach%0d", tag, n), 32'(acc_q.size() >= n), 32'd1);
  endtask

  // START is sampled on the edge whose count is returned; outputs clear one edge later.
  task automatic pulse_start(output int s);
    START = 1'b1;
    @(negedge REF_CLK);
    START = 1'b0;
    s = cyc;
    @(negedge REF_CLK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rel;
    int s;

    // Reset values, power-up latency, all-ack sequence.
    repeat (3) @(negedge REF_CLK);
    check("rst_valid", 32'(CMD_VALID), 32'd0);
    check("rst_dev", 32'(CMD_DEV), 32'd0);
    check("rst_reg", 32'(CMD_REG), 32'd0);
    check("rst_data", 32'(CMD_DATA), 32'd0);
    check("rst_busy", 32'(I2C_BUSY), 32'd1);
    check("rst_done", 32'(CONFIG_DONE), 32'd0);
    check("rst_led", 32'(I2C_ERROR_LED), 32'd0);
    check("rst_idx", 32'(ENTRY_IDX), 32'd0);
    RESET_CONFIG = 1'b1;
    rel = cyc;
    wait_terminal("ack", 2000);
    add_sequence(-1, 0);
    compare_log("ack");
    check("pwrup_latency", rise_q[0] - rel, P + 1);
    check("cmd_gap", rise_q[1] - (acc_cyc_q[0] + 3), 2);
    check("done_latency", cyc - (acc_cyc_q[N-1] + 3), 2);
    check("ack_busy", 32'(I2C_BUSY), 32'd0);
    check("ack_done", 32'(CONFIG_DONE), 32'd1);
    check("ack_led", 32'(I2C_ERROR_LED), 32'd0);
    check("ack_idx", 32'(ENTRY_IDX), N - 1);

    // Backpressure on entry 5 via a START re-run.
    clear_logs();
    ready_mode = 2;
    bp_cnt = 0;
    pulse_start(s);
    check("rerun_done_clr", 32'(CONFIG_DONE), 32'd0);
    check("rerun_busy", 32'(I2C_BUSY), 32'd1);
    wait_terminal("bp", 2000);
    add_sequence(-1, 0);
    compare_log("bp");
    check("bp_stall", acc_cyc_q[5] - rise_q[5], 8);
    check("bp_no_pwrup", 32'(rise_q[0] - s < P), 32'd1);

    // Random ready and spurious responses, single NACK on entry 2.
    clear_logs();
    ready_mode = 1;
    nack_entry = 2;
    nack_left = 1;
    pulse_start(s);
    wait_terminal("nack1", 4000);
    add_sequence(2, 1);
    compare_log("nack1");
    check("nack_gap", rise_q[3] - (acc_cyc_q[2] + 3), G + 1);
    check("nack1_done", 32'(CONFIG_DONE), 32'd1);
    check("nack1_led", 32'(I2C_ERROR_LED), 32'd0);

    // Four NACKs on entry 7 exhaust the retries.
    clear_logs();
    ready_mode = 0;
    nack_entry = 7;
    nack_left = 4;
    pulse_start(s);
    wait_terminal("err", 3000);
    add_sequence(7, 4);
    compare_log("err");
    check("err_led", 32'(I2C_ERROR_LED), 32'd1);
    check("err_idx", 32'(ENTRY_IDX), 32'd7);
    check("err_busy", 32'(I2C_BUSY), 32'd1);
    check("err_done", 32'(CONFIG_DONE), 32'd0);
    repeat (30) @(negedge REF_CLK);
    check("err_idle", acc_q.size(), 11);
    check("err_led_hold", 32'(I2C_ERROR_LED), 32'd1);
    clear_logs();
    pulse_start(s);
    check("err_led_clr", 32'(I2C_ERROR_LED), 32'd0);
    check("err_rerun_busy", 32'(I2C_BUSY), 32'd1);
    wait_terminal("err_rerun", 2000);
    add_sequence(-1, 0);
    compare_log("err_rerun");
    check("err_no_pwrup", 32'(rise_q[0] - s < P), 32'd1);

    // Hot-plug during entry 4, then again during the re-run.
    clear_logs();
    pulse_start(s);
    wait_size("hpd1", 5, 500);
    HPD = 1'b1;
    repeat (6) @(negedge REF_CLK);
    HPD = 1'b0;
    wait_size("hpd2", N + 3, 1000);
    HPD = 1'b1;
    repeat (6) @(negedge REF_CLK);
    HPD = 1'b0;
    wait_terminal("hpd", 3000);
    repeat (3) add_sequence(-1, 0);
    compare_log("hpd");
    repeat (40) @(negedge REF_CLK);
    check("hpd_no_extra", acc_q.size(), 3 * N);

    // Reset while waiting for the response to entry 9.
    clear_logs();
    pulse_start(s);
    wait_size("rst9", 10, 500);
    #2 RESET_CONFIG = 1'b0;
    #1;
    check("mid_rst_valid", 32'(CMD_VALID), 32'd0);
    check("mid_rst_busy", 32'(I2C_BUSY), 32'd1);
    check("mid_rst_idx", 32'(ENTRY_IDX), 32'd0);
    check("mid_rst_done", 32'(CONFIG_DONE), 32'd0);
    repeat (2) @(negedge REF_CLK);
    clear_logs();
    RESET_CONFIG = 1'b1;
    rel = cyc;
    wait_terminal("post_rst", 2000);
    add_sequence(-1, 0);
    compare_log("post_rst");
    check("post_rst_pwrup", rise_q[0] - rel, P + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
